// File: rtl/fir_seq_pkg.sv
// Shared types and width helpers for the time-multiplexed FIR MAC sequencer.
package fir_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_e;

    localparam int DW_DEF   = 4;
    localparam int TAPS_DEF = 4;

    // A single tap would still need one address bit to keep the ports legal.
    function automatic int aw_f(input int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

    // Sum of TAPS full-width products never exceeds this width.
    function automatic int accw_f(input int dw, input int taps);
        return 2 * dw + aw_f(taps);
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// TAPS x DW coefficient register file: async clear, enable-gated write, combinational read.
module fir_coef_bank
    import fir_seq_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int TAPS = TAPS_DEF,
    parameter int AW   = aw_f(TAPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] coef_q [TAPS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                coef_q[k] <= '0;
            end
        end else if (wr_en) begin
            for (int k = 0; k < TAPS; k++) begin
                if (wr_addr == AW'(k)) begin
                    coef_q[k] <= wr_data;
                end
            end
        end
    end

    assign rd_data = coef_q[rd_addr];

endmodule

// File: rtl/fir_mac_sequencer.sv
// FIR controller sharing one external signed multiplier across all taps.
// Optional macro FIR_SEQ_SAT_EN: saturate the output and add the sat flag.
module fir_mac_sequencer
    import fir_seq_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int TAPS = TAPS_DEF,
    parameter int AW   = aw_f(TAPS),
    parameter int ACCW = accw_f(DW, TAPS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic            coef_we,
    input  logic [AW-1:0]   coef_addr,
    input  logic [DW-1:0]   coef_data,
    output logic [DW-1:0]   mul_a,
    output logic [DW-1:0]   mul_b,
    input  logic [2*DW-1:0] mul_p,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*DW-1:0] out_data,
    output logic            busy
`ifdef FIR_SEQ_SAT_EN
    ,
    output logic            sat
`endif
);

    state_e          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic [DW-1:0]   x_q [TAPS];
    logic            shift_en;
    logic            coef_wr_en;
    logic [DW-1:0]   coef_rd;

    fir_coef_bank #(
        .DW   (DW),
        .TAPS (TAPS),
        .AW   (AW)
    ) u_coef_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (coef_wr_en),
        .wr_addr (coef_addr),
        .wr_data (coef_data),
        .rd_addr (idx_q),
        .rd_data (coef_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
            end
        end else if (shift_en) begin
            x_q[0] <= in_data;
            for (int k = 1; k < TAPS; k++) begin
                x_q[k] <= x_q[k-1];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        mul_a      = '0;
        mul_b      = '0;
        shift_en   = 1'b0;
        coef_wr_en = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready   = 1'b1;
                // Writes only land here so one result never mixes two coefficient sets.
                coef_wr_en = coef_we;
                if (in_valid) begin
                    shift_en = 1'b1;
                    acc_d    = '0;
                    idx_d    = '0;
                    state_d  = MAC;
                end
            end
            MAC: begin
                busy  = 1'b1;
                mul_a = x_q[idx_q];
                mul_b = coef_rd;
                acc_d = acc_q + {{(ACCW-2*DW){mul_p[2*DW-1]}}, mul_p};
                idx_d = idx_q + 1'b1;
                if (idx_q == AW'(TAPS-1)) begin
                    idx_d   = '0;
                    state_d = OUT;
                end
            end
            OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef FIR_SEQ_SAT_EN
    logic ovf_hi, ovf_lo;

    // Overflow when the bits above the output sign are not a sign extension of it.
    assign ovf_hi = !acc_q[ACCW-1] && (acc_q[ACCW-2:2*DW-1] != '0);
    assign ovf_lo =  acc_q[ACCW-1] && (acc_q[ACCW-2:2*DW-1] != '1);
    assign sat    = out_valid && (ovf_hi || ovf_lo);

    always_comb begin
        out_data = '0;
        if (out_valid) begin
            if (ovf_hi) begin
                out_data = {1'b0, {(2*DW-1){1'b1}}};
            end else if (ovf_lo) begin
                out_data = {1'b1, {(2*DW-1){1'b0}}};
            end else begin
                out_data = acc_q[2*DW-1:0];
            end
        end
    end
`else
    logic acc_unused;

    assign acc_unused = ^acc_q[ACCW-1:2*DW];
    assign out_data   = out_valid ? acc_q[2*DW-1:0] : '0;
`endif

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with a result scoreboard and a behavioural multiplier.
module tb_fir_mac_sequencer;

    localparam int DW   = 4;
    localparam int TAPS = 4;
    localparam int AW   = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW-1:0]   in_data = '0;
    logic            coef_we = 1'b0;
    logic [AW-1:0]   coef_addr = '0;
    logic [DW-1:0]   coef_data = '0;
    logic [DW-1:0]   mul_a;
    logic [DW-1:0]   mul_b;
    logic [2*DW-1:0] mul_p;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [2*DW-1:0] out_data;
    logic            busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int txn = 0;

    int mc [TAPS];
    int mx [TAPS];
    int exp_q [$];
    int acc_cyc_q [$];

    fir_mac_sequencer #(
        .DW   (DW),
        .TAPS (TAPS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // Shared signed 4x4 multiplier, combinational.
    assign mul_p = $signed(mul_a) * $signed(mul_b);

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
            $error("check %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < TAPS; k++) begin
            mc[k] = 0;
            mx[k] = 0;
        end
    endtask

    task automatic write_coef(input int addr, input int val, input bit applies);
        coef_addr = AW'(addr);
        coef_data = DW'(val);
        coef_we   = 1'b1;
        @(negedge clk);
        coef_we = 1'b0;
        if (applies) mc[addr] = val;
    endtask

    task automatic send(input int v);
        int n;
        int s;
        n = 0;
        in_data  = DW'(v);
        in_valid = 1'b1;
        while (!in_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
        mx[0] = v;
        s = 0;
        for (int k = 0; k < TAPS; k++) s += mc[k] * mx[k];
        exp_q.push_back(s & 8'hFF);
        acc_cyc_q.push_back(cyc);
        @(negedge clk);
        in_valid = 1'b0;
        chk("busy_in_mac", 32'(busy), 32'd1);
        chk("in_ready_in_mac", 32'(in_ready), 32'd0);
    endtask

    task automatic recv(input int hold, input int junk);
        int n;
        int e;
        int a;
        logic [2*DW-1:0] d0;
        n = 0;
        while (!out_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            chk("out_valid_timeout", 32'(out_valid), 32'd1);
            return;
        end
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'(exp_q.size()), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        a = acc_cyc_q.pop_front();
        chk("latency", 32'(cyc - a), 32'(TAPS + 1));
        d0 = out_data;
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = DW'(junk);
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(d0));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("out_data", 32'(out_data), 32'(e));
        $display("txn %0d: out_data=0x%02h expected=0x%02h", txn, out_data, e[7:0]);
        txn++;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_after_out", 32'(in_ready), 32'd1);
        chk("valid_drop_after_out", 32'(out_valid), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    initial begin
        model_clear();
        do_reset();

        // Reset state
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mul_a", 32'(mul_a), 32'd0);
        chk("rst_mul_b", 32'(mul_b), 32'd0);

        // Basic filter with c = {1,2,3,4}: 1, 4, 10
        write_coef(0, 1, 1'b1);
        write_coef(1, 2, 1'b1);
        write_coef(2, 3, 1'b1);
        write_coef(3, 4, 1'b1);
        send(1); recv(0, 0);
        send(2); recv(0, 0);
        send(3); recv(0, 0);

        // Backpressure: result held, in_valid pulses ignored, delay line unchanged
        send(4); recv(3, 9);
        send(5); recv(0, 0);

        // Coefficient write during MAC is dropped; in IDLE it lands
        send(6);
        write_coef(0, 7, 1'b0);
        recv(0, 0);
        send(1); recv(0, 0);
        write_coef(0, 7, 1'b1);
        send(2); recv(0, 0);

        // Reset in the middle of MAC (idx = 2)
        send(3);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_mul_a", 32'(mul_a), 32'd0);
        chk("midrst_mul_b", 32'(mul_b), 32'd0);
        void'(exp_q.pop_back());
        void'(acc_cyc_q.pop_back());
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        send(5); recv(0, 0);

        // Signed corner: c0 = -8, x0 = -8
        write_coef(0, -8, 1'b1);
        send(-8);
        chk("corner_mul_a", 32'(mul_a), 32'h8);
        chk("corner_mul_b", 32'(mul_b), 32'h8);
        recv(0, 0);

        // All coefficients -8: 64 then wrap of 128
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(k, -8, 1'b1);
        send(-8); recv(0, 0);
        send(-8); recv(0, 0);
        chk("idle_mul_a", 32'(mul_a), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
